// File: rtl/reg_to_apb_master.sv
// Register-bus to APB4 initiator bridge: one outstanding transfer, all APB outputs registered.
// Optional ACCESS-phase timeout is compiled in with `define REG_TO_APB_MASTER_TIMEOUT_EN.

package reg_to_apb_master_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 32;
  localparam int unsigned APB_DATA_WIDTH = 32;
  localparam int unsigned APB_STRB_WIDTH = APB_DATA_WIDTH / 8;

  typedef struct packed {
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [2:0]                pprot;
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_DATA_WIDTH-1:0] pwdata;
    logic [APB_STRB_WIDTH-1:0] pstrb;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                      pready;
    logic                      pslverr;
  } apb_rsp_t;

endpackage

module reg_to_apb_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter type         apb_req_t      = reg_to_apb_master_pkg::apb_req_t,
  parameter type         apb_rsp_t      = reg_to_apb_master_pkg::apb_rsp_t
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    reg_valid_i,
  input  logic                    reg_write_i,
  input  logic [ADDR_WIDTH-1:0]   reg_addr_i,
  input  logic [DATA_WIDTH-1:0]   reg_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] reg_wstrb_i,
  output logic                    reg_ready_o,
  output logic [DATA_WIDTH-1:0]   reg_rdata_o,
  output logic                    reg_error_o,
  output apb_req_t                apb_req_o,
  input  apb_rsp_t                apb_rsp_i,
  output logic                    busy_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("reg_to_apb_master: TIMEOUT_CYCLES must be at least 1");
  end

  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("reg_to_apb_master: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  apb_req_t              req_q, req_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  error_q, error_d;

`ifdef REG_TO_APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Completion outputs default to zero so they are high only in the DONE cycle.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ready_d = 1'b0;
    rdata_d = '0;
    error_d = 1'b0;
`ifdef REG_TO_APB_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (reg_valid_i) begin
          req_d.paddr   = reg_addr_i;
          req_d.pprot   = 3'b000;
          req_d.psel    = 1'b1;
          req_d.penable = 1'b0;
          req_d.pwrite  = reg_write_i;
          req_d.pwdata  = reg_write_i ? reg_wdata_i : '0;
          req_d.pstrb   = reg_write_i ? reg_wstrb_i : {STRB_WIDTH{1'b0}};
          state_d       = SETUP;
        end
      end

      SETUP: begin
        req_d.penable = 1'b1;
        state_d       = ACCESS;
`ifdef REG_TO_APB_MASTER_TIMEOUT_EN
        cnt_d         = '0;
`endif
      end

      ACCESS: begin
        if (apb_rsp_i.pready) begin
          req_d.psel    = 1'b0;
          req_d.penable = 1'b0;
          ready_d       = 1'b1;
          rdata_d       = req_q.pwrite ? '0 : apb_rsp_i.prdata;
          error_d       = apb_rsp_i.pslverr;
          state_d       = DONE;
        end
`ifdef REG_TO_APB_MASTER_TIMEOUT_EN
        // This stalled cycle is the one that brings the count to the limit.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_d.psel    = 1'b0;
          req_d.penable = 1'b0;
          ready_d       = 1'b1;
          error_d       = 1'b1;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
`ifdef REG_TO_APB_MASTER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
`ifdef REG_TO_APB_MASTER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign apb_req_o   = req_q;
  assign reg_ready_o = ready_q;
  assign reg_rdata_o = rdata_q;
  assign reg_error_o = error_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_reg_to_apb_master.sv
// Randomized bench for reg_to_apb_master: acts as requester and APB slave, checks every cycle
// of each transfer against a transaction-level model of the expected phase timeline.

module tb_reg_to_apb_master;

  localparam int TO = 4;
`ifdef REG_TO_APB_MASTER_TIMEOUT_EN
  localparam bit timeoutOn = 1'b1;
`else
  localparam bit timeoutOn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        reg_valid_i = 1'b0;
  logic        reg_write_i = 1'b0;
  logic [31:0] reg_addr_i = '0;
  logic [31:0] reg_wdata_i = '0;
  logic [3:0]  reg_wstrb_i = '0;
  logic        reg_ready_o;
  logic [31:0] reg_rdata_o;
  logic        reg_error_o;
  logic        busy_o;
  reg_to_apb_master_pkg::apb_req_t apb_req_o;
  reg_to_apb_master_pkg::apb_rsp_t apb_rsp_i = '0;

  int checkCount = 0;
  int errorCount = 0;

  reg_to_apb_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .reg_valid_i(reg_valid_i),
    .reg_write_i(reg_write_i),
    .reg_addr_i (reg_addr_i),
    .reg_wdata_i(reg_wdata_i),
    .reg_wstrb_i(reg_wstrb_i),
    .reg_ready_o(reg_ready_o),
    .reg_rdata_o(reg_rdata_o),
    .reg_error_o(reg_error_o),
    .apb_req_o  (apb_req_o),
    .apb_rsp_i  (apb_rsp_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkApb(input string tag, input logic psel, input logic pen, input logic [31:0] addr,
                          input logic wr, input logic [31:0] wdata, input logic [3:0] strb);
    checkOutput({tag, ".psel"},    32'(apb_req_o.psel),    32'(psel));
    checkOutput({tag, ".penable"}, 32'(apb_req_o.penable), 32'(pen));
    checkOutput({tag, ".paddr"},   apb_req_o.paddr,        addr);
    checkOutput({tag, ".pwrite"},  32'(apb_req_o.pwrite),  32'(wr));
    checkOutput({tag, ".pwdata"},  apb_req_o.pwdata,       wdata);
    checkOutput({tag, ".pstrb"},   32'(apb_req_o.pstrb),   32'(strb));
    checkOutput({tag, ".pprot"},   32'(apb_req_o.pprot),   32'h0);
  endtask

  task automatic checkReg(input string tag, input logic busy, input logic ready,
                          input logic [31:0] rdata, input logic err);
    checkOutput({tag, ".busy"},  32'(busy_o),      32'(busy));
    checkOutput({tag, ".ready"}, 32'(reg_ready_o), 32'(ready));
    checkOutput({tag, ".rdata"}, reg_rdata_o,      rdata);
    checkOutput({tag, ".error"}, 32'(reg_error_o), 32'(err));
  endtask

  // One full transfer: the model predicts the phase of every cycle from the wait count alone.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input int waits, input logic [31:0] rdataIn,
                               input logic slvErr, input logic holdNext, input string name);
    logic [31:0] expWdata;
    logic [3:0]  expStrb;
    logic [31:0] expRdata;
    logic        expErr;
    bit          timedOut;
    int          accessCycles;

    expWdata     = wr ? wdata : 32'h0;
    expStrb      = wr ? strb : 4'h0;
    timedOut     = timeoutOn && (waits >= TO);
    accessCycles = timedOut ? TO : waits + 1;
    expRdata     = (timedOut || wr) ? 32'h0 : rdataIn;
    expErr       = timedOut ? 1'b1 : slvErr;

    @(negedge clk_i);
    reg_valid_i = 1'b1;
    reg_write_i = wr;
    reg_addr_i  = addr;
    reg_wdata_i = wdata;
    reg_wstrb_i = strb;
    apb_rsp_i   = '0;

    @(posedge clk_i); #1;
    checkApb({name, ".setup"}, 1'b1, 1'b0, addr, wr, expWdata, expStrb);
    checkReg({name, ".setup"}, 1'b1, 1'b0, 32'h0, 1'b0);

    // Request bus churns during the transfer; the bridge must ignore it.
    @(negedge clk_i);
    reg_write_i = 1'($urandom_range(0, 1));
    reg_addr_i  = $urandom;
    reg_wdata_i = $urandom;
    reg_wstrb_i = 4'($urandom);

    for (int j = 0; j < accessCycles; j++) begin
      @(posedge clk_i); #1;
      checkApb($sformatf("%s.access%0d", name, j), 1'b1, 1'b1, addr, wr, expWdata, expStrb);
      checkReg($sformatf("%s.access%0d", name, j), 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk_i);
      apb_rsp_i.pready  = (j == waits);
      apb_rsp_i.prdata  = (j == waits) ? rdataIn : $urandom;
      apb_rsp_i.pslverr = (j == waits) ? slvErr : 1'($urandom_range(0, 1));
      reg_addr_i        = $urandom;
    end

    @(posedge clk_i); #1;
    checkOutput({name, ".done.psel"},    32'(apb_req_o.psel),    32'h0);
    checkOutput({name, ".done.penable"}, 32'(apb_req_o.penable), 32'h0);
    checkReg({name, ".done"}, 1'b1, 1'b1, expRdata, expErr);

    @(negedge clk_i);
    apb_rsp_i = '0;
    if (holdNext) begin
      reg_valid_i = 1'b1;
      reg_write_i = 1'($urandom_range(0, 1));
      reg_addr_i  = $urandom;
      reg_wdata_i = $urandom;
      reg_wstrb_i = 4'($urandom);
    end else begin
      reg_valid_i = 1'b0;
    end

    @(posedge clk_i); #1;
    checkOutput({name, ".idle.psel"}, 32'(apb_req_o.psel), 32'h0);
    checkReg({name, ".idle"}, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic        wr;
    int          waits;

    #2 rst_ni = 1'b0;
    #1;
    checkApb("reset", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    checkReg("reset", 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, $urandom, 1'b0, 1'b0, "wr0");
    applyStimulus(1'b0, 32'h04, $urandom, 4'hF, 3, 32'h0000_00A5, 1'b0, 1'b0, "rdWait");
    applyStimulus(1'b0, 32'h08, $urandom, 4'h0, 1, 32'h1234_5678, 1'b1, 1'b1, "rdErr");
    applyStimulus(1'b1, 32'h0C, 32'h55AA55AA, 4'h3, 2, 32'hFFFF_FFFF, 1'b0, 1'b0, "wrB2b");
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 20, 32'h0000_0077, 1'b0, 1'b0, "stall");
    applyStimulus(1'b1, 32'h24, $urandom, 4'h5, TO - 1, $urandom, 1'b1, 1'b0, "edge");

    for (int n = 0; n < 40; n++) begin
      wr    = 1'($urandom_range(0, 1));
      waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 10)) : int'($urandom_range(0, 3));
      applyStimulus(wr, $urandom, $urandom, 4'($urandom), waits, $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    // Reset asserted between clock edges while the slave is stalling in ACCESS.
    @(negedge clk_i);
    reg_valid_i = 1'b1;
    reg_write_i = 1'b1;
    reg_addr_i  = 32'h40;
    reg_wdata_i = 32'hCAFE_F00D;
    reg_wstrb_i = 4'hF;
    apb_rsp_i   = '0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 checkOutput("preRst.penable", 32'(apb_req_o.penable), 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    checkApb("midRst", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    checkReg("midRst", 1'b0, 1'b0, 32'h0, 1'b0);
    reg_valid_i = 1'b0;
    @(posedge clk_i); #1;
    checkReg("inRst", 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    checkReg("postRst", 1'b0, 1'b0, 32'h0, 1'b0);

    applyStimulus(1'b0, 32'h44, $urandom, 4'hA, 1, 32'hBEEF_0001, 1'b0, 1'b0, "afterRst");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
